// File: rtl/mux_nto1_scan_pkg.sv
// rtl/mux_nto1_scan_pkg.sv - shared types and channel-search helpers for mux_nto1_scan
package mux_nto1_scan_pkg;

    // Search helpers cover up to 64 channels; idx is wide enough for any of them.
    localparam int MAX_CH = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_e;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
        logic       wrapped;
    } next_bit_t;

    function automatic int sel_width(input int n_ch);
        return $clog2(n_ch);
    endfunction

    // First set bit strictly after ptr, circularly over n_ch channels.
    // Passing ptr = n_ch-1 yields the lowest set bit.
    function automatic next_bit_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                               input int n_ch, input int ptr);
        next_bit_t r;
        int        c;
        r = '0;
        for (int i = 1; i <= MAX_CH; i++) begin
            c = ptr + i;
            if (c >= n_ch) c = c - n_ch;
            if (i <= n_ch && !r.found && mask[c[5:0]]) begin
                r.found   = 1'b1;
                r.idx     = c[5:0];
                r.wrapped = (c <= ptr);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_scan_ptr.sv
// rtl/mux_nto1_scan_ptr.sv - combinational next/lowest enabled-channel finder
module mux_nto1_scan_ptr
    import mux_nto1_scan_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [SEL_W-1:0] ptr,
    output logic             any_set,
    output logic [SEL_W-1:0] next_idx,
    output logic             next_wraps,
    output logic [SEL_W-1:0] first_idx
);

    logic [MAX_CH-1:0] mask_ext;
    next_bit_t         nb;
    next_bit_t         fb;

    assign mask_ext = MAX_CH'(ch_mask);

    always_comb begin
        nb = next_set_bit(mask_ext, N_CH, int'(ptr));
        fb = next_set_bit(mask_ext, N_CH, N_CH - 1);
    end

    // The search from ptr visits every channel, ptr included, so found means mask != 0.
    assign any_set    = nb.found | fb.found;
    assign next_idx   = nb.idx[SEL_W-1:0];
    assign next_wraps = nb.wrapped & fb.wrapped;
    assign first_idx  = fb.idx[SEL_W-1:0];

endmodule

// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - registered N:1 mux with direct select and masked auto-scan
module mux_nto1_scan
    import mux_nto1_scan_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = sel_width(N_CH),
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_bus,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_ch,
    output logic              y_valid,
    output logic              frame_done
);

    localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int N_SLOT = 2 ** SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   y_ch_q, y_ch_d;
    logic               y_valid_q, y_valid_d;
    logic               frame_done_q, frame_done_d;

    logic               any_set;
    logic [SEL_W-1:0]   next_idx;
    logic               next_wraps;
    logic [SEL_W-1:0]   first_idx;
    logic [W-1:0]       ch_data [N_SLOT];

    // Slots past N_CH read as zero so an out-of-range select yields y=0.
    for (genvar c = 0; c < N_SLOT; c++) begin : g_slot
        if (c < N_CH) begin : g_real
            assign ch_data[c] = in_bus[c*W +: W];
        end else begin : g_pad
            assign ch_data[c] = '0;
        end
    end

    mux_nto1_scan_ptr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_ptr (
        .ch_mask    (ch_mask),
        .ptr        (ptr_q),
        .any_set    (any_set),
        .next_idx   (next_idx),
        .next_wraps (next_wraps),
        .first_idx  (first_idx)
    );

    always_comb begin
        state_d      = !en ? ST_IDLE : (mode ? ST_SCAN : ST_DIRECT);
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        y_d          = y_q;
        y_ch_d       = y_ch_q;
        y_valid_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                y_d       = ch_data[sel];
                y_ch_d    = sel;
                y_valid_d = (int'(sel) < N_CH);
            end
            ST_SCAN: begin
                // armed_q clears while the mask is empty, forcing a fresh entry later.
                if (state_q != ST_SCAN || !armed_q) begin
                    cnt_d = '0;
                    if (any_set) begin
                        ptr_d   = first_idx;
                        armed_d = 1'b1;
                    end
                end else if (!any_set) begin
                    armed_d = 1'b0;
                end else if (!ch_mask[ptr_q]) begin
                    ptr_d        = next_idx;
                    cnt_d        = '0;
                    frame_done_d = next_wraps;
                end else begin
                    y_d       = ch_data[ptr_q];
                    y_ch_d    = ptr_q;
                    y_valid_d = 1'b1;
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        cnt_d        = '0;
                        ptr_d        = next_idx;
                        frame_done_d = next_wraps;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            y_q          <= '0;
            y_ch_q       <= '0;
            y_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            y_q          <= y_d;
            y_ch_q       <= y_ch_d;
            y_valid_q    <= y_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign y          = y_q;
    assign y_ch       = y_ch_q;
    assign y_valid    = y_valid_q;
    assign frame_done = frame_done_q;

endmodule
